tsc_capture: RTL and testbench

Parametrised transient signal capture block. It sits between the ADC array front-end and the external controller. It handshakes samples from the ADC into a power-of-two ring buffer, keeps pre-trigger history, and arms on a runtime threshold. After the trigger it captures a fixed number of post-trigger samples, timestamps the trigger, then serialises the stored window oldest-first on request.

---
 rtl/tsc_capture_if.sv | 28 ++
 rtl/tsc_capture.sv | 194 +++++++++++++++++++
 tb/tb_tsc_capture.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tsc_capture_if.sv
// Signal bundle between tsc_capture and its ADC front-end / external controller.
// The master side drives control and ADC samples; the slave side is the capture block.
interface tsc_capture_if #(
  parameter int DW = 8,
  parameter int TW = 32
);
  logic          start;
  logic          sbf;
  logic [DW-1:0] thresh;
  logic          rdy;
  logic [DW-1:0] dat;
  logic          req;
  logic          rst;
  logic          trd;
  logic [TW-1:0] trig_tm;
  logic          cd;
  logic          sd;

  modport master (
    output start, sbf, thresh, rdy, dat,
    input  req, rst, trd, trig_tm, cd, sd
  );

  modport slave (
    input  start, sbf, thresh, rdy, dat,
    output req, rst, trd, trig_tm, cd, sd
  );
endinterface

// File: rtl/tsc_capture.sv
// Transient capture: ring buffer with pre-trigger history, threshold trigger, timestamp and serial dump.
// Define TSC_CAPTURE_EDGE_TRIG_EN for a rising-edge trigger; otherwise the trigger is level-based.
module tsc_capture #(
  parameter int DW    = 8,
  parameter int DEPTH = 32,
  parameter int POST  = 16,
  parameter int TW    = 32
) (
  input  logic         clk,
  input  logic         reset,
  tsc_capture_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(POST + 1);
  localparam int BW = $clog2(DW + 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECORD,
    ST_POST,
    ST_DONE,
    ST_SEND
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DW-1:0] r_buf [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] w_rdNext;
  logic [AW-1:0] w_origin;
  logic [FW-1:0] r_fill;
  logic [FW-1:0] r_framesLeft;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] r_trigTm;
  logic [PW-1:0] r_postCnt;
  logic [BW-1:0] r_bitIdx;
  logic [DW-1:0] r_shift;
  logic          r_trd;
  logic          r_cd;
  logic          r_sd;
  logic          r_rstHold;

  logic w_req;
  logic w_startTake;
  logic w_sendTake;
  logic w_accept;
  logic w_trigHit;
  logic w_trig;
  logic w_postDone;
  logic w_lastBit;
  logic w_sendDone;

  assign w_req       = (r_state == ST_RECORD) || (r_state == ST_POST);
  assign w_startTake = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sendTake  = (r_state == ST_DONE) && bus.sbf && !bus.start;
  assign w_accept    = w_req && bus.rdy;
  assign w_trig      = (r_state == ST_RECORD) && w_accept && w_trigHit;
  assign w_postDone  = (r_state == ST_POST) && w_accept && (r_postCnt == PW'(1));
  assign w_lastBit   = (r_bitIdx == BW'(DW + 1));
  assign w_sendDone  = (r_state == ST_SEND) && w_lastBit && (r_framesLeft == FW'(1));
  assign w_rdNext    = r_rdPtr + AW'(1);
  assign w_origin    = (r_fill == FW'(DEPTH)) ? r_wrPtr : '0;

`ifdef TSC_CAPTURE_EDGE_TRIG_EN
  logic [DW-1:0] r_prevDat;
  logic          r_prevValid;

  assign w_trigHit = (bus.dat > bus.thresh) && r_prevValid && (r_prevDat <= bus.thresh);

  // The first sample of a capture has no predecessor, so it can never be an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prevDat   <= '0;
      r_prevValid <= 1'b0;
    end else if (w_startTake) begin
      r_prevValid <= 1'b0;
    end else if (w_accept) begin
      r_prevDat   <= bus.dat;
      r_prevValid <= 1'b1;
    end
  end
`else
  assign w_trigHit = (bus.dat > bus.thresh);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_startTake) w_nextState = ST_RECORD;
      ST_RECORD: if (w_trig) w_nextState = ST_POST;
      ST_POST:   if (w_postDone) w_nextState = ST_DONE;
      ST_DONE: begin
        if (w_startTake)     w_nextState = ST_RECORD;
        else if (w_sendTake) w_nextState = ST_SEND;
      end
      ST_SEND:   if (w_sendDone) w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Sample storage has no reset so captured data survives an abort.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wrPtr] <= bus.dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_fill       <= '0;
      r_framesLeft <= '0;
      r_timer      <= '0;
      r_trigTm     <= '0;
      r_postCnt    <= '0;
      r_bitIdx     <= '0;
      r_shift      <= '0;
      r_trd        <= 1'b0;
      r_cd         <= 1'b0;
      r_sd         <= 1'b1;
      r_rstHold    <= 1'b1;
    end else begin
      r_rstHold <= 1'b0;
      if (w_startTake) begin
        r_wrPtr <= '0;
        r_fill  <= '0;
        r_timer <= '0;
        r_trd   <= 1'b0;
        r_cd    <= 1'b0;
      end else begin
        if (w_req) r_timer <= r_timer + TW'(1);
        if (w_accept) begin
          r_wrPtr <= r_wrPtr + AW'(1);
          if (r_fill != FW'(DEPTH)) r_fill <= r_fill + FW'(1);
        end
        if (w_trig) begin
          r_trigTm  <= r_timer;
          r_postCnt <= PW'(POST);
        end
        if ((r_state == ST_POST) && w_accept) begin
          r_postCnt <= r_postCnt - PW'(1);
          if (w_postDone) r_trd <= 1'b1;
        end
        if (w_sendTake) begin
          r_rdPtr      <= w_origin;
          r_shift      <= r_buf[w_origin];
          r_framesLeft <= r_fill;
          r_bitIdx     <= '0;
          r_sd         <= 1'b0;
        end
        // Bit index 0 is the start bit, 1..DW the data MSB first, DW+1 the stop bit.
        if (r_state == ST_SEND) begin
          if (w_lastBit) begin
            if (r_framesLeft == FW'(1)) begin
              r_cd  <= 1'b1;
              r_sd  <= 1'b1;
              r_trd <= 1'b0;
            end else begin
              r_framesLeft <= r_framesLeft - FW'(1);
              r_rdPtr      <= w_rdNext;
              r_shift      <= r_buf[w_rdNext];
              r_bitIdx     <= '0;
              r_sd         <= 1'b0;
            end
          end else if (r_bitIdx < BW'(DW)) begin
            r_sd     <= r_shift[DW-1];
            r_shift  <= r_shift << 1;
            r_bitIdx <= r_bitIdx + BW'(1);
          end else begin
            r_sd     <= 1'b1;
            r_bitIdx <= r_bitIdx + BW'(1);
          end
        end
      end
    end
  end

  // rst is high out of reset until the first clock, and for the cycle a start is taken.
  assign bus.req     = w_req;
  assign bus.rst     = r_rstHold | w_startTake;
  assign bus.trd     = r_trd;
  assign bus.trig_tm = r_trigTm;
  assign bus.cd      = r_cd;
  assign bus.sd      = r_sd;

endmodule

// File: tb/tb_tsc_capture.sv
// Directed bench for tsc_capture: a stimulus-side model of the ring buffer feeds a scoreboard
// of expected serial frames, which are popped and compared as they appear on sd.
module tb_tsc_capture;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int POST  = 16;
  localparam int TW    = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tsc_capture_if #(.DW(DW), .TW(TW)) bus ();

  tsc_capture #(.DW(DW), .DEPTH(DEPTH), .POST(POST), .TW(TW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int            nChecks = 0;
  int            nPass   = 0;
  int            recCycle;
  int            lastTm;
  int            tmTrig;
  int            expTrig;
  logic [DW-1:0] model[$];
  logic [DW-1:0] expQ[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic doStart(input logic withSbf);
    bus.start = 1'b1;
    bus.sbf   = withSbf;
    #1;
    check("rst_pulse", bus.rst, 1);
    check("req_during_pulse", bus.req, 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.sbf   = 1'b0;
    #1;
    check("rst_after_pulse", bus.rst, 0);
    check("req_in_record", bus.req, 1);
    check("trd_cleared", bus.trd, 0);
    check("cd_cleared", bus.cd, 0);
    check("sd_idle_record", bus.sd, 1);
    model.delete();
    recCycle = 0;
  endtask

  // One cycle of ADC traffic; v=0 is a cycle with rdy low.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic v);
    bus.dat  = d;
    bus.rdy  = v;
    lastTm   = recCycle;
    recCycle++;
    if (v) begin
      model.push_back(d);
      if (model.size() > DEPTH) void'(model.pop_front());
    end
    @(negedge clk);
    bus.rdy = 1'b0;
  endtask

  // Requests a dump and compares up to maxFrames frames against the scoreboard.
  task automatic checkOutput(input int maxFrames);
    logic [DW+1:0] fr;
    logic [DW-1:0] e;
    expQ = model;
    check("cd_before_send", bus.cd, 0);
    bus.sbf = 1'b1;
    @(negedge clk);
    bus.sbf = 1'b0;
    for (int f = 0; f < maxFrames && expQ.size() > 0; f++) begin
      for (int b = DW + 1; b >= 0; b--) begin
        fr[b] = bus.sd;
        @(negedge clk);
      end
      e = expQ.pop_front();
      check($sformatf("frame%0d", f), fr, {1'b0, e, 1'b1});
    end
  endtask

  task automatic checkSendDone();
    check("cd_after_send", bus.cd, 1);
    check("sd_after_send", bus.sd, 1);
    check("trd_after_send", bus.trd, 0);
    check("req_after_send", bus.req, 0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.sbf    = 1'b0;
    bus.rdy    = 1'b0;
    bus.dat    = '0;
    bus.thresh = 8'hD5;
`ifdef TSC_CAPTURE_EDGE_TRIG_EN
    expTrig = 2;
`else
    expTrig = 0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_req", bus.req, 0);
    check("reset_rst", bus.rst, 1);
    check("reset_trd", bus.trd, 0);
    check("reset_cd", bus.cd, 0);
    check("reset_sd", bus.sd, 1);
    check("reset_trig_tm", bus.trig_tm, 0);
    reset = 1'b0;
    #1;
    check("rst_held_until_clk", bus.rst, 1);
    @(negedge clk);
    check("rst_released", bus.rst, 0);
    check("idle_req", bus.req, 0);

    // Basic capture with level/edge trigger on 0xD6
    doStart(1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(8'(i), 1'b1);
    applyStimulus(8'hD6, 1'b1);
    check("t1_trig_tm", bus.trig_tm, 10);
    check("t1_req_post", bus.req, 1);
    for (int i = 0; i < POST - 1; i++) applyStimulus(8'h11, 1'b1);
    check("t1_trd_early", bus.trd, 0);
    applyStimulus(8'h11, 1'b1);
    check("t1_trd", bus.trd, 1);
    check("t1_req_done", bus.req, 0);
    @(negedge clk);
    check("t1_trd_hold", bus.trd, 1);
    check("t1_trig_tm_hold", bus.trig_tm, 10);

    // Dump of the 27 captured samples
    checkOutput(DEPTH + 1);
    checkSendDone();
    @(negedge clk);
    check("t2_cd_hold", bus.cd, 1);

    // Wrap-around: only the newest DEPTH samples survive
    doStart(1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(8'(i), 1'b1);
    applyStimulus(8'hFF, 1'b1);
    check("t3_trig_tm", bus.trig_tm, lastTm);
    for (int i = 0; i < POST; i++) applyStimulus(8'h05, 1'b1);
    check("t3_trd", bus.trd, 1);
    checkOutput(DEPTH + 1);
    checkSendDone();

    // sbf in RECORD ignored; rdy gaps keep the timer running; start in POST ignored
    doStart(1'b0);
    bus.sbf = 1'b1;
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h03, 1'b1);
    check("t4_sd_sbf_record", bus.sd, 1);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    check("t4_sd_sbf_gap", bus.sd, 1);
    applyStimulus(8'hD6, 1'b1);
    tmTrig = lastTm;
    bus.sbf = 1'b0;
    check("t4_trig_tm_gap", bus.trig_tm, 5);
    for (int i = 0; i < 5; i++) applyStimulus(8'h22, 1'b1);
    bus.start = 1'b1;
    #1;
    check("t4_rst_start_post", bus.rst, 0);
    applyStimulus(8'h23, 1'b1);
    bus.start = 1'b0;
    check("t4_trig_tm_kept", bus.trig_tm, tmTrig);
    check("t4_req_continue", bus.req, 1);
    for (int i = 0; i < POST - 6; i++) applyStimulus(8'h24, 1'b1);
    check("t4_trd", bus.trd, 1);

    // start together with sbf in DONE: start wins; then trigger-mode sequence
    doStart(1'b1);
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'h10, 1'b1);
    applyStimulus(8'hE0, 1'b1);
    check("t6_trig_tm", bus.trig_tm, expTrig);
    for (int i = 0; i < POST - (2 - expTrig); i++) applyStimulus(8'h33, 1'b1);
    check("t6_trd", bus.trd, 1);

    // Asynchronous reset in the middle of the second frame
    checkOutput(1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_sd", bus.sd, 1);
    check("t5_cd", bus.cd, 0);
    check("t5_trd", bus.trd, 0);
    check("t5_req", bus.req, 0);
    check("t5_rst", bus.rst, 1);
    check("t5_trig_tm", bus.trig_tm, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_rst_held", bus.rst, 1);
    @(negedge clk);
    check("t5_rst_released", bus.rst, 0);
    check("t5_sd_idle", bus.sd, 1);
    check("t5_req_idle", bus.req, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
